t07_fpu_div_ctrl: RTL

T07_FPU_DIV_CTRL -- requirements
Module: t07_fpu_div_ctrl

---
 rtl/t07_fpu_pkg.sv | 42 ++++
 rtl/t07_fpu_div_step.sv | 29 ++
 rtl/t07_fpu_div_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/t07_fpu_pkg.sv
// Shared definitions for the binary32 divider controller: FSM states,
// field widths, encodings of the special results and small result helpers.
package t07_fpu_pkg;

    localparam int WORD_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SIG_W  = MAN_W + 1;   // significand with hidden one
    localparam int REM_W  = SIG_W + 1;   // partial remainder, < 2 * divisor
    localparam int QUO_W  = SIG_W + 2;   // 24 mantissa bits + guard + round
    localparam int EXPI_W = 10;          // signed working exponent
    localparam int BIAS   = 127;

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

    // Iteration counter runs 0..QUO_W-1, one quotient bit per count.
    localparam logic [4:0] LAST_STEP = 5'(QUO_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic logic [WORD_W-1:0] signed_inf(input logic sign);
        return {sign, POS_INF[WORD_W-2:0]};
    endfunction

    function automatic logic [WORD_W-1:0] signed_zero(input logic sign);
        return {sign, {(WORD_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/t07_fpu_div_step.sv
// One restoring-division step: compare the partial remainder with the
// divisor, subtract when it fits, and shift the remainder left for the next
// quotient bit.
module t07_fpu_div_step
    import t07_fpu_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic [SIG_W-1:0] divisor,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    logic [REM_W:0]   diff;
    logic [REM_W-1:0] kept;
    logic             kept_msb_unused;

    // Trial subtraction; a clear borrow bit means the divisor fits.
    always_comb begin
        diff    = {1'b0, rem_in} - {2'b00, divisor};
        q_bit   = ~diff[REM_W];
        kept    = q_bit ? diff[REM_W-1:0] : rem_in;
        // The kept remainder is always below the divisor, so its top bit is
        // zero and the shift cannot lose information.
        rem_out = {kept[REM_W-2:0], 1'b0};
    end

    assign kept_msb_unused = kept[REM_W-1];

endmodule

// File: rtl/t07_fpu_div_ctrl.sv
// Sequential binary32 divider: IDLE -> UNPACK -> DIVIDE (26 cycles) -> NORM
// -> DONE, with special operands short-cut from UNPACK straight to DONE.
// Define T07_FPU_DIV_RNE_EN for round-to-nearest-even; the default build
// truncates (round toward zero) with identical latency.
module t07_fpu_div_ctrl
    import t07_fpu_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [WORD_W-1:0] inA,
    input  logic [WORD_W-1:0] inB,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              div_by_zero,
    output logic              invalid,
    output logic              overflow
);

    state_t state, state_nx;

    fp32_t                     a_q, b_q;
    logic                      sign_q;
    logic signed [EXPI_W-1:0]  exp_q;
    logic [SIG_W-1:0]          div_q;
    logic [REM_W-1:0]          rem_q;
    logic [QUO_W-1:0]          quo_q;
    logic [4:0]                cnt_q;

    // Operand classification (subnormals count as zero)
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, special, sign_u;
    logic [WORD_W-1:0] spec_res;
    logic              spec_dbz, spec_inv;

    // Divider step
    logic [REM_W-1:0] step_rem;
    logic             step_q;

    // Normalisation and rounding
    logic [SIG_W-1:0]         mant24;
    logic                     guard, rnd, sticky, round_inc;
    logic signed [EXPI_W-1:0] exp_n, exp_f;
    logic [SIG_W:0]           mant_r;
    logic [MAN_W-1:0]         mant_f;
    logic [WORD_W-1:0]        norm_res;
    logic                     norm_ovf;

    t07_fpu_div_step u_step (
        .rem_in  (rem_q),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_UNPACK;
            ST_UNPACK: state_nx = special ? ST_DONE : ST_DIVIDE;
            ST_DIVIDE: if (cnt_q == LAST_STEP) state_nx = ST_NORM;
            ST_NORM:   state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Classify latched operands and pick the short-cut result if special.
    always_comb begin
        a_zero   = (a_q.exp == '0);
        b_zero   = (b_q.exp == '0);
        a_inf    = (a_q.exp == '1) && (a_q.man == '0);
        b_inf    = (b_q.exp == '1) && (b_q.man == '0);
        a_nan    = (a_q.exp == '1) && (a_q.man != '0);
        b_nan    = (b_q.exp == '1) && (b_q.man != '0);
        sign_u   = a_q.sign ^ b_q.sign;
        special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        spec_res = signed_zero(sign_u);
        spec_dbz = 1'b0;
        spec_inv = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = signed_inf(sign_u);
        end else if (b_zero) begin
            spec_res = signed_inf(sign_u);
            spec_dbz = 1'b1;
        end
    end

    // Normalise the raw quotient and extract guard/round/sticky.
    always_comb begin
        if (quo_q[QUO_W-1]) begin
            mant24 = quo_q[QUO_W-1:2];
            guard  = quo_q[1];
            rnd    = quo_q[0];
            exp_n  = exp_q;
        end else begin
            mant24 = quo_q[QUO_W-2:1];
            guard  = quo_q[0];
            rnd    = 1'b0;
            exp_n  = exp_q - 10'sd1;
        end
        sticky = |rem_q;
    end

`ifdef T07_FPU_DIV_RNE_EN
    assign round_inc = guard & (rnd | sticky | mant24[0]);
`else
    logic grs_unused;
    assign round_inc  = 1'b0;
    assign grs_unused = guard | rnd | sticky;
`endif

    // Apply rounding, renormalise a carry-out, and range-check the exponent.
    always_comb begin
        mant_r = {1'b0, mant24} + {{SIG_W{1'b0}}, round_inc};
        if (mant_r[SIG_W]) begin
            mant_f = mant_r[SIG_W-1:1];
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_r[MAN_W-1:0];
            exp_f  = exp_n;
        end
        norm_ovf = 1'b0;
        if (exp_f >= 10'sd255) begin
            norm_res = signed_inf(sign_q);
            norm_ovf = 1'b1;
        end else if (exp_f <= 10'sd0) begin
            norm_res = signed_zero(sign_q);
        end else begin
            norm_res = {sign_q, exp_f[EXP_W-1:0], mant_f};
        end
    end

    // Datapath registers: operand latch, unpack, iterate, commit result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q         <= inA;
                        b_q         <= inB;
                        div_by_zero <= 1'b0;
                        invalid     <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                ST_UNPACK: begin
                    sign_q <= sign_u;
                    exp_q  <= $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp})
                              + 10'(BIAS);
                    div_q  <= {1'b1, b_q.man};
                    rem_q  <= {2'b01, a_q.man};
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    if (special) begin
                        result      <= spec_res;
                        div_by_zero <= spec_dbz;
                        invalid     <= spec_inv;
                    end
                end
                ST_DIVIDE: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[QUO_W-2:0], step_q};
                    cnt_q <= (cnt_q == LAST_STEP) ? 5'd0 : cnt_q + 5'd1;
                end
                ST_NORM: begin
                    result   <= norm_res;
                    overflow <= norm_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule
